// File: rtl/strobe_tracker_pkg.sv
// Shared types and default parameters for the strobe tracker.
package strobe_tracker_pkg;

  // Tracker FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEAS   = 2'd1,
    LOCKED = 2'd2
  } trk_state_t;

  // Default parameters: 8-bit period, lock after 4 matches, +/-1 cycle jitter
  localparam int PW_DEF      = 8;
  localparam int LOCK_N_DEF  = 4;
  localparam int TOL_DEF     = 1;
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/edge_det.sv
// Rise detector plus registered rise/fall clock-enable pulses for a level input.
// The combinational rise is exposed so a consumer can act in the same cycle.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic rise_q,
  output logic fall_q
);

  logic d_q;

  assign rise = d & ~d_q;

  // Previous-sample register and one-cycle-late pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      d_q    <= d;
      rise_q <= d & ~d_q;
      fall_q <= ~d & d_q;
    end
  end

endmodule

// File: rtl/strobe_tracker.sv
// Tracks a periodic strobe: emits rise/fall enables, measures the period,
// declares lock after LOCK_N consecutive in-tolerance periods, flags loss.
module strobe_tracker
  import strobe_tracker_pkg::*;
#(
  parameter int PW      = PW_DEF,
  parameter int LOCK_N  = LOCK_N_DEF,
  parameter int TOL     = TOL_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          strb,
  output logic          ce_rise,
  output logic          ce_fall,
  output logic [PW-1:0] period,
  output logic          locked,
  output logic          lost
);

  localparam logic [PW-1:0] CNT_MAX  = '1;
  localparam logic [PW-1:0] TO_VAL   = PW'(TIMEOUT);
  localparam logic [PW:0]   TOL_VAL  = (PW+1)'(TOL);
  localparam logic [3:0]    LOCK_VAL = 4'(LOCK_N);

  trk_state_t    state, state_nx;
  logic          rise;
  logic [PW-1:0] cnt, ref_p;
  logic          ref_v, ref_v_nx;
  logic [3:0]    match, match_nx;
  logic [PW:0]   c_ext, r_ext, diff;
  logic          in_tol, tmo;
  logic          ref_ld, per_ld, lost_nx;

  edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .d      (strb),
    .rise   (rise),
    .rise_q (ce_rise),
    .fall_q (ce_fall)
  );

  // Unsigned magnitude of the period change, one bit wider than the counter
  assign c_ext  = {1'b0, cnt};
  assign r_ext  = {1'b0, ref_p};
  assign diff   = (c_ext >= r_ext) ? (c_ext - r_ext) : (r_ext - c_ext);
  assign in_tol = (diff <= TOL_VAL);
  // A rise in the timeout cycle wins over the timeout
  assign tmo    = (cnt == TO_VAL) && !rise;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and datapath controls
  always_comb begin
    state_nx = state;
    ref_v_nx = ref_v;
    match_nx = match;
    ref_ld   = 1'b0;
    per_ld   = 1'b0;
    lost_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nx = MEAS;
          ref_v_nx = 1'b0;
          match_nx = '0;
        end
      end
      MEAS: begin
        if (rise) begin
          ref_ld = 1'b1;
          if (!ref_v) begin
            ref_v_nx = 1'b1;
          end else begin
            match_nx = in_tol ? match + 4'd1 : 4'd0;
            if (match_nx == LOCK_VAL) begin
              state_nx = LOCKED;
              per_ld   = 1'b1;
            end
          end
        end else if (tmo) begin
          state_nx = IDLE;
        end
      end
      LOCKED: begin
        if (rise) begin
          ref_ld = 1'b1;
          if (in_tol) begin
            per_ld = 1'b1;
          end else begin
            state_nx = MEAS;
            match_nx = '0;
            ref_v_nx = 1'b1;
            lost_nx  = 1'b1;
          end
        end else if (tmo) begin
          state_nx = IDLE;
          lost_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Period counter, reference, match count and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      ref_p  <= '0;
      ref_v  <= 1'b0;
      match  <= '0;
      period <= '0;
      locked <= 1'b0;
      lost   <= 1'b0;
    end else begin
      if (rise)                cnt <= PW'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (ref_ld) ref_p  <= cnt;
      if (per_ld) period <= cnt;
      ref_v  <= ref_v_nx;
      match  <= match_nx;
      locked <= (state_nx == LOCKED);
      lost   <= lost_nx;
    end
  end

endmodule

// File: tb/tb_strobe_tracker.sv
// Randomized bench for strobe_tracker against an event-level reference model.
module tb_strobe_tracker;
  import strobe_tracker_pkg::*;

  localparam int PW = 8, LOCK_N = 4, TOL = 1, TIMEOUT = 255, CMAX = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          strb = 1'b0;
  logic          ce_rise, ce_fall, locked, lost;
  logic [PW-1:0] period;

  int checks = 0, passes = 0;
  int cyc = 0, bad = 0, bad_cyc = 0;
  logic [11:0] bad_o, bad_e;

  // Reference model state: time since last rise, mode (0 idle/1 measuring/2 locked)
  int m_sq, m_el, m_st, m_ref, m_rv, m_match, m_per, m_lck, m_lost, m_cer, m_cef;

  strobe_tracker #(.PW(PW), .LOCK_N(LOCK_N), .TOL(TOL), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .strb(strb), .ce_rise(ce_rise), .ce_fall(ce_fall),
    .period(period), .locked(locked), .lost(lost)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Apply the spec rules for one sampled strobe value
  function automatic void model_step(input bit s);
    int r, f, el, d;
    if (rst) begin
      m_sq = 0; m_el = 0; m_st = 0; m_ref = 0; m_rv = 0; m_match = 0;
      m_per = 0; m_lck = 0; m_lost = 0; m_cer = 0; m_cef = 0;
      return;
    end
    r  = (s && m_sq == 0) ? 1 : 0;
    f  = (!s && m_sq == 1) ? 1 : 0;
    el = m_el;
    d  = (el > m_ref) ? el - m_ref : m_ref - el;
    m_lost = 0;
    case (m_st)
      0: if (r != 0) begin m_st = 1; m_rv = 0; m_match = 0; end
      1: if (r != 0) begin
           if (m_rv == 0) m_rv = 1;
           else begin
             m_match = (d <= TOL) ? m_match + 1 : 0;
             if (m_match == LOCK_N) begin m_st = 2; m_per = el; end
           end
           m_ref = el;
         end else if (el == TIMEOUT) m_st = 0;
      default: if (r != 0) begin
           if (d <= TOL) m_per = el;
           else begin m_st = 1; m_match = 0; m_rv = 1; m_lost = 1; end
           m_ref = el;
         end else if (el == TIMEOUT) begin m_st = 0; m_lost = 1; end
    endcase
    m_el  = (r != 0) ? 1 : ((el < CMAX) ? el + 1 : CMAX);
    m_sq  = s ? 1 : 0;
    m_cer = r;
    m_cef = f;
    m_lck = (m_st == 2) ? 1 : 0;
  endfunction

  // Drive one cycle, advance the model, record any cycle-level divergence
  task automatic tick(input bit s);
    logic [11:0] o, e;
    strb = s;
    @(posedge clk);
    model_step(s);
    @(negedge clk);
    cyc++;
    o = {ce_rise, ce_fall, locked, lost, period};
    e = {m_cer[0], m_cef[0], m_lck[0], m_lost[0], m_per[7:0]};
    if (o !== e) begin
      if (bad == 0) begin bad_o = o; bad_e = e; bad_cyc = cyc; end
      bad++;
    end
  endtask

  // n periods of length p (half high); reports the rise count when lock first shows
  task automatic run_periods(input int p, input int n, output int lock_rise);
    int nr;
    nr = 0;
    lock_rise = -1;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < p; k++) begin
        tick(k < p / 2);
        if (ce_rise) nr++;
        if (locked && lock_rise == -1) lock_rise = ce_rise ? nr : -100 - nr;
      end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick(i == 0);
    rst = 1'b0;
    checks++;
    if ({ce_rise, ce_fall, locked, lost, period} !== 12'd0)
      $display("FAIL reset_outputs: got %h want 000", {ce_rise, ce_fall, locked, lost, period});
    else passes++;
    checks++;
    if (dut.state !== IDLE) $display("FAIL reset_state: got %0d want IDLE", dut.state);
    else passes++;
  endtask

  task automatic test_lock16();
    int lr;
    bad = 0;
    run_periods(16, 8, lr);
    checks++;
    if (lr !== LOCK_N + 2) $display("FAIL lock16_time: lock at rise %0d want %0d", lr, LOCK_N + 2);
    else passes++;
    checks++;
    if (period !== 8'd16 || locked !== 1'b1)
      $display("FAIL lock16_period: period=%0d locked=%b want 16/1", period, locked);
    else passes++;
    checks++;
    if (bad !== 0) $display("FAIL lock16_model: %0d bad cycles, first @%0d got %h want %h", bad, bad_cyc, bad_o, bad_e);
    else passes++;
  endtask

  task automatic test_fractional();
    int nlost, nunl, p;
    bad = 0; nlost = 0; nunl = 0;
    for (int i = 0; i < 24; i++) begin
      p = ($urandom_range(3, 0) == 0) ? 15 : 16;
      for (int k = 0; k < p; k++) begin
        tick(k < p / 2);
        if (lost) nlost++;
        if (!locked) nunl++;
      end
    end
    checks++;
    if (nlost !== 0 || nunl !== 0)
      $display("FAIL frac_hold: lost=%0d unlocked_cycles=%0d want 0/0", nlost, nunl);
    else passes++;
    checks++;
    if (bad !== 0) $display("FAIL frac_model: %0d bad cycles, first @%0d got %h want %h", bad, bad_cyc, bad_o, bad_e);
    else passes++;
  endtask

  task automatic test_glitch();
    int nlost, sawdrop, p;
    bad = 0; nlost = 0; sawdrop = 0;
    for (int i = 0; i < 7; i++) begin
      p = (i == 0) ? 20 : 16;
      for (int k = 0; k < p; k++) begin
        tick(k < p / 2);
        if (lost) nlost++;
        if (!locked) sawdrop = 1;
      end
    end
    checks++;
    if (nlost !== 1 || sawdrop !== 1)
      $display("FAIL glitch_lost: lost=%0d dropped=%0d want 1/1", nlost, sawdrop);
    else passes++;
    checks++;
    if (locked !== 1'b1 || period !== 8'd16)
      $display("FAIL glitch_relock: locked=%b period=%0d want 1/16", locked, period);
    else passes++;
    checks++;
    if (bad !== 0) $display("FAIL glitch_model: %0d bad cycles, first @%0d got %h want %h", bad, bad_cyc, bad_o, bad_e);
    else passes++;
  endtask

  task automatic test_timeout();
    int nlost;
    bad = 0; nlost = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1'b0);
      if (lost) nlost++;
    end
    checks++;
    if (nlost !== 1 || locked !== 1'b0 || period !== 8'd16)
      $display("FAIL timeout: lost=%0d locked=%b period=%0d want 1/0/16", nlost, locked, period);
    else passes++;
    checks++;
    if (dut.state !== IDLE) $display("FAIL timeout_state: got %0d want IDLE", dut.state);
    else passes++;
    checks++;
    if (bad !== 0) $display("FAIL timeout_model: %0d bad cycles, first @%0d got %h want %h", bad, bad_cyc, bad_o, bad_e);
    else passes++;
  endtask

  task automatic test_rise_at_timeout();
    bad = 0;
    tick(1'b1);
    for (int i = 0; i < TIMEOUT - 1; i++) tick(1'b0);
    tick(1'b1);
    checks++;
    if (dut.state !== MEAS || dut.ref_p !== 8'd255)
      $display("FAIL rise_tmo: state=%0d ref=%0d want MEAS/255", dut.state, dut.ref_p);
    else passes++;
    checks++;
    if (bad !== 0) $display("FAIL rise_tmo_model: %0d bad cycles, first @%0d got %h want %h", bad, bad_cyc, bad_o, bad_e);
    else passes++;
  endtask

  task automatic test_mid_reset();
    int lr;
    bad = 0;
    run_periods(16, 8, lr);
    checks++;
    if (locked !== 1'b1) $display("FAIL pre_reset_lock: locked=%b want 1", locked);
    else passes++;
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    checks++;
    if ({ce_rise, ce_fall, locked, lost, period} !== 12'd0 || dut.state !== IDLE)
      $display("FAIL mid_reset: outs=%h state=%0d want 000/IDLE", {ce_rise, ce_fall, locked, lost, period}, dut.state);
    else passes++;
    run_periods(16, 8, lr);
    checks++;
    if (lr !== LOCK_N + 2 || period !== 8'd16)
      $display("FAIL relock_after_reset: rise=%0d period=%0d want %0d/16", lr, period, LOCK_N + 2);
    else passes++;
    checks++;
    if (bad !== 0) $display("FAIL mid_reset_model: %0d bad cycles, first @%0d got %h want %h", bad, bad_cyc, bad_o, bad_e);
    else passes++;
  endtask

  task automatic test_toggle();
    int nalt;
    bad = 0; nalt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(i % 2 == 0);
      if (i >= 20 && (ce_rise ^ ce_fall) === 1'b1 && ce_rise === ((i % 2 == 0) ? 1'b1 : 1'b0)) nalt++;
    end
    checks++;
    if (nalt !== 20) $display("FAIL toggle_alt: alternating cycles=%0d want 20", nalt);
    else passes++;
    checks++;
    if (locked !== 1'b1 || period !== 8'd2)
      $display("FAIL toggle_lock: locked=%b period=%0d want 1/2", locked, period);
    else passes++;
    checks++;
    if (bad !== 0) $display("FAIL toggle_model: %0d bad cycles, first @%0d got %h want %h", bad, bad_cyc, bad_o, bad_e);
    else passes++;
  endtask

  task automatic test_random();
    int p, pj, hi;
    bad = 0;
    for (int seg = 0; seg < 30; seg++) begin
      p = $urandom_range(40, 3);
      for (int i = 0; i < 10; i++) begin
        pj = p + $urandom_range(2, 0) - 1;
        hi = $urandom_range(pj - 1, 1);
        for (int k = 0; k < pj; k++) tick(k < hi);
      end
      if ($urandom_range(5, 0) == 0)
        for (int k = 0; k < $urandom_range(270, 240); k++) tick(1'b0);
    end
    checks++;
    if (bad !== 0) $display("FAIL random_model: %0d bad cycles, first @%0d got %h want %h", bad, bad_cyc, bad_o, bad_e);
    else passes++;
  endtask

  initial begin
    model_step(1'b0);
    @(negedge clk);
    test_reset();
    test_lock16();
    test_fractional();
    test_glitch();
    test_timeout();
    test_rise_at_timeout();
    test_mid_reset();
    test_toggle();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
